kyber_parse: RTL
================

# kyber_parse

Consumer of the Keccak squeeze stream: pulls 64-bit words out of the Keccak output FIFO with the `gimme`/`out_ready` handshake and performs Kyber uniform rejection sampling (Parse). Each 3-byte group gives two 12-bit candidates, and candidates below q = 3329 are emitted as polynomial coefficients until 256 have been accepted. It sits between the Keccak top (mode SHAKE128 / XOF) and the NTT-domain matrix storage.

## Interface
- Q, 3329, modulus; a candidate is accepted iff it is < Q
- N, 256, number of coefficients per polynomial
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new polynomial and aborts any one in progress
- kw_valid  in  1  Keccak output FIFO non-empty (Keccak `out_ready`)
- kw_data  in  64  Keccak FIFO read data, valid the cycle after a read
- kw_gimme  out  1  read request to Keccak; when the FIFO is empty, this also requests a squeeze
- coef  out  12  accepted coefficient
- coef_valid  out  1  `coef` is valid
- coef_ready  in  1  downstream accepts `coef`
- coef_idx  out  8  index 0..255 of the presented coefficient
- busy  out  1  high from the cycle after `start` until `done`
- done  out  1  level; high after coefficient 255 is accepted, cleared by `start`
- rej_cnt  out  10  rejected-candidate count, saturating (only with `KYBER_PARSE_REJCNT_EN`)

## Operation
- **Byte order.** `kw_data[7:0]` is stream byte 0 and `kw_data[63:56]` is byte 7.
- **Byte buffer.** The buffer is 80 bits, with `avail` ranging 0..10 bytes. A captured word is appended above the existing bytes, starting at byte position `avail`.
- **Read rule.** `kw_gimme` = `busy` & (`avail` < 3) & ~`rd_pend`.
  - A read occurs on a cycle where `kw_gimme` & `kw_valid`. That cycle sets `rd_pend`.
  - On the next cycle, `kw_data` is captured, `avail` increases by 8, and `rd_pend` clears.
  - `kw_gimme` with `kw_valid` low is legal and is held until `kw_valid` rises.
- **States.**
  - IDLE → FILL on `start`. Entering FILL clears `avail`, `rd_pend` and the coefficient count.
  - FILL: stay while `avail` < 3; → SPLIT when `avail` ≥ 3.
  - SPLIT: takes bytes b0, b1, b2.
    - d1 = b0 + 256·(b1 & 0xF).
    - d2 = (b1 >> 4) + 16·b2.
    - Shift the buffer down 3 bytes, set `avail` −= 3, then → EMIT1.
  - EMIT1: if d1 < Q, hold `coef`=d1 with `coef_valid` until `coef_ready`. If d1 ≥ Q, spend exactly one cycle with no output. Then → EMIT2.
  - EMIT2: same as EMIT1 for d2. Then → FILL, or → DONE once the count reaches 256.
  - DONE: `done`=1 and `busy`=0. Stays until `start` (→ FILL).
- If coefficient 255 is accepted from d1, d2 is discarded without being evaluated. Bytes left in the buffer are discarded.
- No reads are issued in IDLE or DONE. An outstanding read captured after DONE is dropped.
- `start` in any state restarts at FILL with a clean buffer. Any read in flight is still consumed, on the following cycle, and discarded.
- The comparison is 12-bit unsigned against Q; no modular reduction is performed.

## Timing
- Reset values: `kw_gimme`=0, `coef`=0, `coef_valid`=0, `coef_idx`=0, `busy`=0, `done`=0, `rej_cnt`=0. State is IDLE and `avail`=0.
- `kw_gimme` rises the cycle after `start`.
- From read cycle t, with no stalls:
  - t+1: capture.
  - t+2: SPLIT.
  - t+3: first `coef_valid`.
- Steady state without stalls: one SPLIT plus two EMIT cycles per 3 bytes. A word read is overlapped with EMIT whenever `avail` < 3.
- `coef`, `coef_valid` and `coef_idx` are registered and stable while `coef_valid` & ~`coef_ready`.
- `done` rises the cycle after the handshake of coefficient 255.

## Configuration
- **`KYBER_PARSE_REJCNT_EN` defined:** the `rej_cnt` port exists.
  - It increments once per rejected candidate and saturates at 1023.
  - It clears on `start`.
- **Not defined:** the port and the counter are absent. Behaviour is otherwise identical.

## Test plan
- **Accept both candidates.** Word 0x…030201 (bytes 01 02 03) → coef 513 (idx 0), then coef 48 (idx 1).
- **Boundary.** Bytes 00 0D 10 → d1=3328 accepted, then d2=256 accepted. Bytes 01 0D 00 → d1=3329 rejected (`rej_cnt`+1), then d2=0 accepted at the next idx.
- **All rejected.**
  - Stimulus: stream of 0xFF bytes, then 00 00 00.
  - Required: no `coef_valid` during the 0xFF bytes, then coef 0 and coef 0 at idx 0 and 1.
  - With the macro defined: `rej_cnt` = 2 × (number of FF triples).
- **Full polynomial.**
  - Stimulus: 48 words of bytes 01 02 03 repeating, with `coef_ready` randomly stalled.
  - Required: 256 coefficients alternating 513/48, idx 0..255, then `done`=1 and `kw_gimme`=0.
- **Empty FIFO.** Hold `kw_valid`=0 for 20 cycles → `kw_gimme` stays 1 and there is no capture. Raise `kw_valid` → capture on the following cycle.
- **Mid-run restart.** `start` after 100 coefficients → idx restarts at 0, the old buffer bytes are not emitted, and `rst` mid-run returns all outputs to their reset values.

Source files
------------

// File: rtl/kyber_parse.sv
// kyber_parse: Kyber uniform rejection sampler (Parse) over the Keccak XOF 64-bit word stream.
// Define KYBER_PARSE_REJCNT_EN to add the saturating rejected-candidate counter port rej_cnt.
module kyber_parse (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kw_valid,
    input  logic [63:0] kw_data,
    output logic        kw_gimme,
    output logic [11:0] coef,
    output logic        coef_valid,
    input  logic        coef_ready,
    output logic [7:0]  coef_idx,
    output logic        busy,
    output logic        done
`ifdef KYBER_PARSE_REJCNT_EN
    ,
    output logic [9:0]  rej_cnt
`endif
);
    localparam logic [11:0] Q        = 12'd3329;
    localparam logic [7:0]  LAST_IDX = 8'd255;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_SPLIT = 3'd2;
    localparam logic [2:0] S_EMIT1 = 3'd3;
    localparam logic [2:0] S_EMIT2 = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state;
    logic [79:0] byte_buf;
    logic [3:0]  avail;
    logic        rd_pend;
    logic [11:0] d2_hold;

    logic        capture;
    logic        accept;
    logic [79:0] buf_base;
    logic [79:0] buf_next;
    logic [3:0]  avail_base;
    logic [3:0]  avail_next;
    logic [11:0] d1;
    logic [11:0] d2;

    assign busy     = (state == S_FILL) || (state == S_SPLIT) ||
                      (state == S_EMIT1) || (state == S_EMIT2);
    assign done     = (state == S_DONE);
    assign kw_gimme = busy && (avail < 4'd3) && !rd_pend;
    assign accept   = coef_valid && coef_ready;

    // Stream byte 0 is the low byte of the buffer; the two candidates share byte 1.
    assign d1 = {byte_buf[11:8], byte_buf[7:0]};
    assign d2 = {byte_buf[23:16], byte_buf[15:12]};

    // Next buffer: drop a consumed triple, then append a captured word above what remains.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        capture    = rd_pend && busy;
        buf_base   = byte_buf;
        avail_base = avail;
        if (state == S_SPLIT) begin
            buf_base   = byte_buf >> 24;
            avail_base = avail - 4'd3;
        end
        buf_next   = buf_base;
        avail_next = avail_base;
        if (capture) begin
            buf_next   = buf_base | ({16'd0, kw_data} << {avail_base, 3'b000});
            avail_next = avail_base + 4'd8;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_buf   <= '0;
            avail      <= '0;
            rd_pend    <= 1'b0;
            d2_hold    <= '0;
            coef       <= '0;
            coef_valid <= 1'b0;
            coef_idx   <= '0;
        end else if (start) begin
            // A read issued this cycle is still popped by Keccak; its data is simply ignored.
            state      <= S_FILL;
            byte_buf   <= '0;
            avail      <= '0;
            rd_pend    <= 1'b0;
            coef_valid <= 1'b0;
            coef_idx   <= '0;
        end else begin
            rd_pend  <= kw_gimme && kw_valid;
            byte_buf <= buf_next;
            avail    <= avail_next;
            case (state)
                S_FILL: begin
                    if (avail_next >= 4'd3) state <= S_SPLIT;
                end
                S_SPLIT: begin
                    coef       <= d1;
                    coef_valid <= (d1 < Q);
                    d2_hold    <= d2;
                    state      <= S_EMIT1;
                end
                S_EMIT1: begin
                    if (accept && coef_idx == LAST_IDX) begin
                        coef_valid <= 1'b0;
                        state      <= S_DONE;
                    end else if (accept || !coef_valid) begin
                        if (accept) coef_idx <= coef_idx + 8'd1;
                        coef       <= d2_hold;
                        coef_valid <= (d2_hold < Q);
                        state      <= S_EMIT2;
                    end
                end
                S_EMIT2: begin
                    if (accept || !coef_valid) begin
                        coef_valid <= 1'b0;
                        if (accept && coef_idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            if (accept) coef_idx <= coef_idx + 8'd1;
                            state <= (avail_next >= 4'd3) ? S_SPLIT : S_FILL;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KYBER_PARSE_REJCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt <= '0;
        end else if (start) begin
            rej_cnt <= '0;
        end else if ((state == S_EMIT1 || state == S_EMIT2) && !coef_valid &&
                     rej_cnt != 10'h3FF) begin
            rej_cnt <= rej_cnt + 10'd1;
        end
    end
`endif

endmodule
